// File: rtl/tb_obi_arb_pkg.sv
// Shared types for the OBI instruction/data memory arbiter.
package tb_obi_arb_pkg;

    // Which master issued a granted request
    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // Instruction fetches always read the full word
    localparam logic [3:0] INSTR_BE = 4'hF;

    // The master that is not the given one
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
    endfunction

endpackage

// File: rtl/tb_obi_owner_fifo.sv
// In-order record of which master owns each granted-but-unanswered request.
module tb_obi_owner_fifo
    import tb_obi_arb_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  logic i_push_owner,
    input  logic i_pop,
    output logic o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    owner_e           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Owner storage; contents are only meaningful below the count, so no reset
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= owner_e'(i_push_owner);
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop keeps the count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tb_obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between instr and data masters.
// A request that is not granted locks the selection until it is, keeping the
// address stable; responses are routed back via the in-order owner FIFO.
module tb_obi_mem_arbiter
    import tb_obi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
)
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  protocol_err_o
);

    owner_e r_rr_last;
    owner_e r_lock_owner;
    logic   r_lock;

    owner_e w_sel;
    logic   w_sel_data;
    logic   w_owner_req;
    logic   w_lock_live;
    logic   w_hs_gnt;
    logic   w_full;
    logic   w_empty;
    logic   w_pop;
    logic   w_head;

    // A lock only holds while its owner keeps requesting; a dropped request
    // releases the selection in the same cycle
    always_comb begin
        w_owner_req = (r_lock_owner == OWNER_DATA) ? data_req_i : instr_req_i;
    end

    assign w_lock_live = r_lock & w_owner_req;

    // Selection: lock first, then a lone requester, else the one not served last
    always_comb begin
        w_sel = other_owner(r_rr_last);
        if (w_lock_live) begin
            w_sel = r_lock_owner;
        end else if (instr_req_i && !data_req_i) begin
            w_sel = OWNER_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            w_sel = OWNER_DATA;
        end
    end

    assign w_sel_data = (w_sel == OWNER_DATA);

    // Memory side: a full owner FIFO blocks new requests even if it pops now
    assign mem_req_o   = (instr_req_i | data_req_i) & ~w_full;
    assign mem_addr_o  = w_sel_data ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = w_sel_data ? data_we_i    : 1'b0;
    assign mem_be_o    = w_sel_data ? data_be_i    : INSTR_BE;
    assign mem_wdata_o = w_sel_data ? data_wdata_i : '0;

    assign w_hs_gnt    = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = w_hs_gnt & ~w_sel_data;
    assign data_gnt_o  = w_hs_gnt & w_sel_data;

    // Response routing; an rvalid with nothing outstanding is flagged, not forwarded
    assign w_pop          = mem_rvalid_i & ~w_empty;
    assign instr_rvalid_o = w_pop & ~w_head;
    assign data_rvalid_o  = w_pop & w_head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign protocol_err_o = mem_rvalid_i & w_empty;

    // Round-robin history and lock: grant releases, stall locks, drop releases
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_last    <= OWNER_INSTR;
            r_lock       <= 1'b0;
            r_lock_owner <= OWNER_INSTR;
        end else if (w_hs_gnt) begin
            r_rr_last <= w_sel;
            r_lock    <= 1'b0;
        end else if (mem_req_o) begin
            r_lock       <= 1'b1;
            r_lock_owner <= w_sel;
        end else if (r_lock && !w_owner_req) begin
            r_lock <= 1'b0;
        end
    end

    tb_obi_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .i_clk        (clk_i),
        .i_rst_n      (rst_ni),
        .i_push       (w_hs_gnt),
        .i_push_owner (w_sel_data),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

endmodule

// File: tb/tb_tb_obi_mem_arbiter.sv
// Self-checking bench for the OBI instr/data memory arbiter.
module tb_tb_obi_mem_arbiter;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        protocol_err_o;

    always #5 clk = ~clk;

    tb_obi_mem_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .protocol_err_o (protocol_err_o)
    );

    // Scoreboard: expected response owner and read data, in grant order
    typedef struct packed {
        logic        own;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void push_exp(input logic own, input logic [31:0] rd);
        exp_t t;
        t.own = own;
        t.rd  = rd;
        sb.push_back(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_addr_i  = '0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_wdata_i = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        sb.delete();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b%b%b%b%b%b want 000000", mem_req_o, instr_gnt_o, data_gnt_o,
                     instr_rvalid_o, data_rvalid_o, protocol_err_o);
        end
        n_vec++;
        if ({mem_addr_o, mem_we_o, mem_wdata_o} !== 65'h0) begin
            n_err++;
            $display("FAIL reset_mem: got addr=%h we=%b wdata=%h want all 0", mem_addr_o, mem_we_o, mem_wdata_o);
        end
        n_vec++;
        if ({instr_rdata_o, data_rdata_o} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h %h want 0", instr_rdata_o, data_rdata_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_instr();
        do_reset();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h180;
        mem_gnt_i    = 1'b1;
        #2;
        n_vec++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o} !== 3'b110) begin
            n_err++;
            $display("FAIL single_gnt: got req/ig/dg=%b%b%b want 110", mem_req_o, instr_gnt_o, data_gnt_o);
        end
        n_vec++;
        if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {32'h180, 1'b0, 4'hF, 32'h0}) begin
            n_err++;
            $display("FAIL single_drive: got addr=%h we=%b be=%h wd=%h want 180 0 f 0", mem_addr_o, mem_we_o,
                     mem_be_o, mem_wdata_o);
        end
        push_exp(OWN_I, 32'hCAFE0180);
        tick();
        idle_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = sb[0].rd;
        #2;
        e = sb.pop_front();
        n_vec++;
        if ({instr_rvalid_o, data_rvalid_o} !== {~e.own, e.own}) begin
            n_err++;
            $display("FAIL single_route: got i/d=%b%b want %b%b", instr_rvalid_o, data_rvalid_o, ~e.own, e.own);
        end
        n_vec++;
        if (instr_rdata_o !== e.rd || data_rdata_o !== e.rd) begin
            n_err++;
            $display("FAIL single_rdata: got i=%h d=%h want %h", instr_rdata_o, data_rdata_o, e.rd);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic own;
            own          = (i % 2 == 0) ? OWN_D : OWN_I;
            instr_req_i  = 1'b1;
            data_req_i   = 1'b1;
            instr_addr_i = 32'h1000 + i * 4;
            data_addr_i  = 32'h2000 + i * 4;
            data_we_i    = 1'b1;
            data_be_i    = 4'h3;
            data_wdata_i = 32'h5500 + i;
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = (sb.size() != 0);
            mem_rdata_i  = (sb.size() != 0) ? sb[0].rd : '0;
            #2;
            if (mem_rvalid_i) begin
                e = sb.pop_front();
                n_vec++;
                if ({instr_rvalid_o, data_rvalid_o} !== {~e.own, e.own}) begin
                    n_err++;
                    $display("FAIL rr_route[%0d]: got i/d=%b%b want %b%b", i, instr_rvalid_o, data_rvalid_o,
                             ~e.own, e.own);
                end
            end
            n_vec++;
            if ({instr_gnt_o, data_gnt_o} !== {~own, own}) begin
                n_err++;
                $display("FAIL rr_gnt[%0d]: got i/d=%b%b want %b%b", i, instr_gnt_o, data_gnt_o, ~own, own);
            end
            n_vec++;
            if ({mem_addr_o, mem_we_o} !== (own ? {data_addr_i, 1'b1} : {instr_addr_i, 1'b0})) begin
                n_err++;
                $display("FAIL rr_drive[%0d]: got addr=%h we=%b", i, mem_addr_o, mem_we_o);
            end
            push_exp(own, 32'hB0B00000 + i);
            tick();
        end
        idle_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = sb[0].rd;
        #2;
        e = sb.pop_front();
        n_vec++;
        if ({instr_rvalid_o, data_rvalid_o} !== {~e.own, e.own} || instr_rdata_o !== e.rd) begin
            n_err++;
            $display("FAIL rr_last_rsp: got i/d=%b%b rdata=%h want %b%b %h", instr_rvalid_o, data_rvalid_o,
                     instr_rdata_o, ~e.own, e.own, e.rd);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        // Both request, memory stalls three cycles: data stays selected
        for (int c = 0; c < 4; c++) begin
            instr_req_i  = 1'b1;
            data_req_i   = 1'b1;
            instr_addr_i = 32'h3000;
            data_addr_i  = 32'h4000;
            data_be_i    = 4'hF;
            mem_gnt_i    = (c == 3);
            #2;
            n_vec++;
            if (mem_addr_o !== 32'h4000 || {instr_gnt_o, data_gnt_o} !== {1'b0, c == 3}) begin
                n_err++;
                $display("FAIL lock_stall[%0d]: got addr=%h i/d=%b%b want 4000 0%b", c, mem_addr_o, instr_gnt_o,
                         data_gnt_o, c == 3);
            end
            tick();
        end
        push_exp(OWN_D, 32'h0D0D0001);
        // Lock taken by a lone data request must survive instr joining
        instr_req_i = 1'b0;
        data_addr_i = 32'h4004;
        mem_gnt_i   = 1'b0;
        tick();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h3004;
        mem_gnt_i    = 1'b1;
        #2;
        n_vec++;
        if (mem_addr_o !== 32'h4004 || {instr_gnt_o, data_gnt_o} !== 2'b01) begin
            n_err++;
            $display("FAIL lock_join: got addr=%h i/d=%b%b want 4004 01", mem_addr_o, instr_gnt_o, data_gnt_o);
        end
        push_exp(OWN_D, 32'h0D0D0002);
        tick();
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = sb[0].rd;
            #2;
            e = sb.pop_front();
            n_vec++;
            if ({instr_rvalid_o, data_rvalid_o} !== {~e.own, e.own} || data_rdata_o !== e.rd) begin
                n_err++;
                $display("FAIL lock_rsp[%0d]: got i/d=%b%b rdata=%h want %b%b %h", k, instr_rvalid_o,
                         data_rvalid_o, data_rdata_o, ~e.own, e.own, e.rd);
            end
            tick();
        end
        // Locked owner drops its request: the lock releases at once
        idle_inputs();
        data_req_i  = 1'b1;
        data_addr_i = 32'h4008;
        tick();
        data_req_i   = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h3008;
        mem_gnt_i    = 1'b1;
        #2;
        n_vec++;
        if (mem_addr_o !== 32'h3008 || {instr_gnt_o, data_gnt_o} !== 2'b10) begin
            n_err++;
            $display("FAIL lock_drop: got addr=%h i/d=%b%b want 3008 10", mem_addr_o, instr_gnt_o, data_gnt_o);
        end
        push_exp(OWN_I, 32'h0D0D0003);
        tick();
        idle_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = sb[0].rd;
        #2;
        e = sb.pop_front();
        n_vec++;
        if ({instr_rvalid_o, data_rvalid_o} !== {~e.own, e.own}) begin
            n_err++;
            $display("FAIL lock_drop_rsp: got i/d=%b%b want %b%b", instr_rvalid_o, data_rvalid_o, ~e.own, e.own);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            instr_req_i  = 1'b1;
            instr_addr_i = 32'h5000 + c * 4;
            mem_gnt_i    = 1'b1;
            #2;
            n_vec++;
            if (instr_gnt_o !== 1'b1) begin
                n_err++;
                $display("FAIL full_fill[%0d]: got gnt=%b want 1", c, instr_gnt_o);
            end
            push_exp(OWN_I, 32'hF0000000 + c);
            tick();
        end
        instr_addr_i = 32'h5008;
        #2;
        n_vec++;
        if ({mem_req_o, instr_gnt_o} !== 2'b00) begin
            n_err++;
            $display("FAIL full_block: got req/gnt=%b%b want 00", mem_req_o, instr_gnt_o);
        end
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = sb[0].rd;
        #2;
        e = sb.pop_front();
        n_vec++;
        if ({mem_req_o, instr_gnt_o} !== 2'b00) begin
            n_err++;
            $display("FAIL full_pop_block: got req/gnt=%b%b want 00", mem_req_o, instr_gnt_o);
        end
        n_vec++;
        if ({instr_rvalid_o, data_rvalid_o} !== {~e.own, e.own} || instr_rdata_o !== e.rd) begin
            n_err++;
            $display("FAIL full_rsp: got i/d=%b%b rdata=%h want %b%b %h", instr_rvalid_o, data_rvalid_o,
                     instr_rdata_o, ~e.own, e.own, e.rd);
        end
        tick();
        mem_rvalid_i = 1'b0;
        #2;
        n_vec++;
        if ({mem_req_o, instr_gnt_o, mem_addr_o} !== {2'b11, 32'h5008}) begin
            n_err++;
            $display("FAIL full_resume: got req/gnt=%b%b addr=%h want 11 5008", mem_req_o, instr_gnt_o, mem_addr_o);
        end
        push_exp(OWN_I, 32'hF0000002);
        tick();
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = sb[0].rd;
            #2;
            e = sb.pop_front();
            n_vec++;
            if ({instr_rvalid_o, data_rvalid_o} !== {~e.own, e.own} || instr_rdata_o !== e.rd) begin
                n_err++;
                $display("FAIL full_drain[%0d]: got i/d=%b%b rdata=%h want %b%b %h", k, instr_rvalid_o,
                         data_rvalid_o, instr_rdata_o, ~e.own, e.own, e.rd);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_push_pop();
        do_reset();
        data_req_i  = 1'b1;
        data_addr_i = 32'h6000;
        data_be_i   = 4'hF;
        mem_gnt_i   = 1'b1;
        #2;
        n_vec++;
        if (data_gnt_o !== 1'b1) begin
            n_err++;
            $display("FAIL pp_first: got dgnt=%b want 1", data_gnt_o);
        end
        push_exp(OWN_D, 32'hAB000001);
        tick();
        data_req_i   = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h6100;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = sb[0].rd;
        #2;
        e = sb.pop_front();
        n_vec++;
        if ({instr_rvalid_o, data_rvalid_o} !== {~e.own, e.own} || data_rdata_o !== e.rd) begin
            n_err++;
            $display("FAIL pp_route: got i/d=%b%b rdata=%h want %b%b %h", instr_rvalid_o, data_rvalid_o,
                     data_rdata_o, ~e.own, e.own, e.rd);
        end
        n_vec++;
        if (instr_gnt_o !== 1'b1) begin
            n_err++;
            $display("FAIL pp_gnt: got ignt=%b want 1", instr_gnt_o);
        end
        push_exp(OWN_I, 32'hAB000002);
        tick();
        // One entry left: exactly one more grant fits before full
        mem_rvalid_i = 1'b0;
        instr_addr_i = 32'h6104;
        #2;
        n_vec++;
        if ({mem_req_o, instr_gnt_o} !== 2'b11) begin
            n_err++;
            $display("FAIL pp_occ1: got req/gnt=%b%b want 11", mem_req_o, instr_gnt_o);
        end
        push_exp(OWN_I, 32'hAB000003);
        tick();
        instr_addr_i = 32'h6108;
        #2;
        n_vec++;
        if (mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL pp_occ2: got req=%b want 0", mem_req_o);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = sb[0].rd;
            #2;
            e = sb.pop_front();
            n_vec++;
            if ({instr_rvalid_o, data_rvalid_o} !== {~e.own, e.own} || instr_rdata_o !== e.rd) begin
                n_err++;
                $display("FAIL pp_drain[%0d]: got i/d=%b%b rdata=%h want %b%b %h", k, instr_rvalid_o,
                         data_rvalid_o, instr_rdata_o, ~e.own, e.own, e.rd);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_protocol_err();
        do_reset();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        #2;
        n_vec++;
        if ({protocol_err_o, instr_rvalid_o, data_rvalid_o} !== 3'b100) begin
            n_err++;
            $display("FAIL perr_empty: got err/i/d=%b%b%b want 100", protocol_err_o, instr_rvalid_o, data_rvalid_o);
        end
        tick();
        mem_rvalid_i = 1'b0;
        #2;
        n_vec++;
        if (protocol_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL perr_pulse: got err=%b want 0", protocol_err_o);
        end
        tick();
        // Grant one data request, then drop it with an async reset pulse
        data_req_i  = 1'b1;
        data_addr_i = 32'h7000;
        mem_gnt_i   = 1'b1;
        #2;
        n_vec++;
        if (data_gnt_o !== 1'b1) begin
            n_err++;
            $display("FAIL perr_gnt: got dgnt=%b want 1", data_gnt_o);
        end
        tick();
        idle_inputs();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        #2;
        n_vec++;
        if ({protocol_err_o, instr_rvalid_o, data_rvalid_o} !== 3'b100) begin
            n_err++;
            $display("FAIL perr_after_rst: got err/i/d=%b%b%b want 100", protocol_err_o, instr_rvalid_o,
                     data_rvalid_o);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_instr();
        test_round_robin();
        test_lock();
        test_full();
        test_push_pop();
        test_protocol_err();
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
